gcd_controller: RTL and testbench

//  FSM that sequences the 16-bit subtractive GCD datapath (regs A/B, 2 operand muxes,

---
 rtl/gcd_controller.sv | 162 ++++++++++++++++
 tb/tb_gcd_controller.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gcd_controller.sv
// Control FSM for the 16-bit subtractive GCD datapath: operand handshake, A-=B / B-=A
// sequencing, iteration watchdog. Optional iter_count output when GCD_ITER_COUNT_EN is defined.
module gcd_controller #(
   parameter int ITER_W   = 16,
   parameter int MAX_ITER = 65535
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              op_valid,
   output logic              op_ready,
   input  logic              abort,
   input  logic              res_ack,
   input  logic              gt,
   input  logic              lt,
   input  logic              eq,
   output logic              ldA,
   output logic              ldB,
   output logic              sel1,
   output logic              sel2,
   output logic              sel_in,
   output logic              done,
   output logic              err
`ifdef GCD_ITER_COUNT_EN
   ,
   output logic [ITER_W-1:0] iter_count
`endif
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_GET_B = 3'd1,
      S_CALC  = 3'd2,
      S_DONE  = 3'd3,
      S_ERR   = 3'd4
   } state_t;

   localparam logic [ITER_W-1:0] C_MAX_ITER = ITER_W'(MAX_ITER);

   state_t            r_state;
   state_t            w_next;
   logic [ITER_W-1:0] r_iter_cnt;
   logic [ITER_W-1:0] w_iter_nxt;
   logic              r_done;
   logic              r_err;
   logic              w_ready;
   logic              w_ld_a;
   logic              w_ld_b;
   logic              w_sel1;
   logic              w_sel2;
   logic              w_sel_in;
   logic              w_flags_legal;
   logic              w_gt;
   logic              w_lt;
   logic              w_eq;

   // A flag set that is not exactly one-hot is handled as "equal" so the FSM stops.
   assign w_flags_legal = (gt & ~lt & ~eq) | (~gt & lt & ~eq) | (~gt & ~lt & eq);
   assign w_gt          = w_flags_legal & gt;
   assign w_lt          = w_flags_legal & lt;
   assign w_eq          = ~w_flags_legal | eq;

   always_comb begin
      w_next     = r_state;
      w_iter_nxt = r_iter_cnt;
      w_ready    = 1'b0;
      w_ld_a     = 1'b0;
      w_ld_b     = 1'b0;
      w_sel1     = 1'b0;
      w_sel2     = 1'b0;
      w_sel_in   = 1'b0;

      case (r_state)
         S_IDLE: begin
            w_ready = 1'b1;
            if (op_valid) begin
               w_ld_a = 1'b1;
               w_next = S_GET_B;
            end
         end
         S_GET_B: begin
            w_ready = 1'b1;
            if (op_valid) begin
               w_ld_b     = 1'b1;
               w_iter_nxt = '0;
               w_next     = S_CALC;
            end
         end
         S_CALC: begin
            // The watchdog test precedes any increment, so the counter cannot pass MAX_ITER.
            if (w_eq) begin
               w_next = S_DONE;
            end else if (r_iter_cnt == C_MAX_ITER) begin
               w_next = S_ERR;
            end else if (w_gt) begin
               w_ld_a     = 1'b1;
               w_sel1     = 1'b1;
               w_sel_in   = 1'b1;
               w_iter_nxt = r_iter_cnt + ITER_W'(1);
            end else if (w_lt) begin
               w_ld_b     = 1'b1;
               w_sel2     = 1'b1;
               w_sel_in   = 1'b1;
               w_iter_nxt = r_iter_cnt + ITER_W'(1);
            end
         end
         S_DONE, S_ERR: begin
            if (res_ack) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase

      if (abort) begin
         w_next     = S_IDLE;
         w_iter_nxt = '0;
         w_ready    = 1'b0;
         w_ld_a     = 1'b0;
         w_ld_b     = 1'b0;
         w_sel1     = 1'b0;
         w_sel2     = 1'b0;
         w_sel_in   = 1'b0;
      end
   end

   // Mealy outputs are forced low for the whole time reset is held.
   assign op_ready = reset_n & w_ready;
   assign ldA      = reset_n & w_ld_a;
   assign ldB      = reset_n & w_ld_b;
   assign sel1     = reset_n & w_sel1;
   assign sel2     = reset_n & w_sel2;
   assign sel_in   = reset_n & w_sel_in;
   assign done     = r_done;
   assign err      = r_err;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= S_IDLE;
         r_iter_cnt <= '0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_state    <= w_next;
         r_iter_cnt <= w_iter_nxt;
         r_done     <= (w_next == S_DONE);
         r_err      <= (w_next == S_ERR);
      end
   end

`ifdef GCD_ITER_COUNT_EN
   logic [ITER_W-1:0] r_iter_count;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_iter_count <= '0;
      end else if ((r_state == S_CALC) && ((w_next == S_DONE) || (w_next == S_ERR))) begin
         r_iter_count <= r_iter_cnt;
      end
   end

   assign iter_count = r_iter_count;
`endif

endmodule

// File: tb/tb_gcd_controller.sv
// Randomized self-checking bench for gcd_controller: two instances (default watchdog and
// MAX_ITER=8) share the host signals, each driving its own behavioural GCD datapath.
module tb_gcd_controller;

   logic        clock;
   logic        reset_n;
   logic        op_valid;
   logic        abort;
   logic        res_ack;
   logic [15:0] data_in;
   logic        force_none;

   logic        gt_m, lt_m, eq_m, op_ready_m, ldA_m, ldB_m, sel1_m, sel2_m, sel_in_m, done_m, err_m;
   logic        gt_w, lt_w, eq_w, op_ready_w, ldA_w, ldB_w, sel1_w, sel2_w, sel_in_w, done_w, err_w;
   logic [15:0] regA, regB, wA, wB;
   logic [15:0] bus_m, bus_w;
`ifdef GCD_ITER_COUNT_EN
   logic [15:0] iter_count_m, iter_count_w;
`endif

   int n_vec = 0;
   int n_err = 0;

   gcd_controller #(.ITER_W(16), .MAX_ITER(65535)) u_dut (
      .clock(clock), .reset_n(reset_n), .op_valid(op_valid), .op_ready(op_ready_m),
      .abort(abort), .res_ack(res_ack), .gt(gt_m), .lt(lt_m), .eq(eq_m),
      .ldA(ldA_m), .ldB(ldB_m), .sel1(sel1_m), .sel2(sel2_m), .sel_in(sel_in_m),
      .done(done_m), .err(err_m)
`ifdef GCD_ITER_COUNT_EN
      , .iter_count(iter_count_m)
`endif
   );

   gcd_controller #(.ITER_W(16), .MAX_ITER(8)) u_wd (
      .clock(clock), .reset_n(reset_n), .op_valid(op_valid), .op_ready(op_ready_w),
      .abort(abort), .res_ack(res_ack), .gt(gt_w), .lt(lt_w), .eq(eq_w),
      .ldA(ldA_w), .ldB(ldB_w), .sel1(sel1_w), .sel2(sel2_w), .sel_in(sel_in_w),
      .done(done_w), .err(err_w)
`ifdef GCD_ITER_COUNT_EN
      , .iter_count(iter_count_w)
`endif
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Datapath models: X/Y operand muxes, subtractor, load mux, registers, comparator.
   assign bus_m = sel_in_m ? ((sel1_m ? regA : regB) - (sel2_m ? regA : regB)) : data_in;
   assign bus_w = sel_in_w ? ((sel1_w ? wA : wB) - (sel2_w ? wA : wB)) : data_in;
   assign gt_m  = ~force_none & (regA > regB);
   assign lt_m  = ~force_none & (regA < regB);
   assign eq_m  = ~force_none & (regA == regB);
   assign gt_w  = wA > wB;
   assign lt_w  = wA < wB;
   assign eq_w  = wA == wB;

   always @(posedge clock) begin
      if (ldA_m) regA <= bus_m;
      if (ldB_m) regB <= bus_m;
      if (ldA_w) wA <= bus_w;
      if (ldB_w) wB <= bus_w;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Reference: Euclid in quotient form; each quotient equals the number of subtractions.
   function automatic void ref_gcd(input int a_in, input int b_in, output int g, output int n);
      int a, b, q;
      a = a_in;
      b = b_in;
      n = 0;
      while (a != b) begin
         if (a > b) begin
            q = (a - 1) / b;
            a = a - q * b;
         end else begin
            q = (b - 1) / a;
            b = b - q * a;
         end
         n = n + q;
      end
      g = a;
   endfunction

   task automatic clean();
      op_valid = 1'b0;
      res_ack  = 1'b0;
      abort    = 1'b1;
      step();
      abort    = 1'b0;
   endtask

   task automatic load(input logic [15:0] a, input logic [15:0] b);
      op_valid = 1'b1;
      data_in  = a;
      step();
      data_in  = b;
      step();
      op_valid = 1'b0;
      data_in  = 16'd0;
   endtask

   task automatic run(input logic [15:0] a, input logic [15:0] b, input string tag);
      int g, n, k;
      ref_gcd(int'(a), int'(b), g, n);
      clean();
      load(a, b);
      k = 0;
      while (!done_m && k < n + 10) begin
         step();
         k++;
      end
      check({tag, ".done"}, done_m, 1);
      check({tag, ".lat"}, k, n + 1);
      check({tag, ".A"}, regA, g);
      check({tag, ".err"}, err_m, 0);
`ifdef GCD_ITER_COUNT_EN
      check({tag, ".iter"}, iter_count_m, n);
`endif
      check({tag, ".wd"}, {err_w, done_w}, (n <= 8) ? 1 : 2);
      res_ack = 1'b1;
      step();
      res_ack = 1'b0;
      check({tag, ".clr"}, {err_m, done_m}, 0);
      check({tag, ".rdy"}, op_ready_m, 1);
   endtask

   initial begin
      int k, pulses;
      logic [15:0] a0, b0;
      reset_n    = 1'b0;
      op_valid   = 1'b0;
      abort      = 1'b0;
      res_ack    = 1'b0;
      data_in    = 16'd0;
      force_none = 1'b0;
      #1;
      check("rst.outs", {op_ready_m, ldA_m, ldB_m, sel1_m, sel2_m, sel_in_m, done_m, err_m}, 0);
      #12;
      reset_n = 1'b1;
      step();
      check("rst.idle_rdy", op_ready_m, 1);
`ifdef GCD_ITER_COUNT_EN
      check("rst.iter", iter_count_m, 0);
`endif

      run(16'd48, 16'd18, "t1");
      run(16'd7, 16'd7, "t2");

      // Zero operand: short watchdog instance must trip after eight B loads.
      clean();
      load(16'd0, 16'd5);
      k = 0;
      pulses = 0;
      while (!err_w && k < 20) begin
         if (ldB_w) pulses++;
         step();
         k++;
      end
      check("t3.err", err_w, 1);
      check("t3.done", done_w, 0);
      check("t3.pulses", pulses, 8);
      check("t3.lat", k, 9);
      check("t3.B", wB, 5);
`ifdef GCD_ITER_COUNT_EN
      check("t3.iter", iter_count_w, 8);
`endif
      res_ack = 1'b1;
      step();
      res_ack = 1'b0;
      check("t3.rdy", op_ready_w, 1);
      check("t3.errclr", err_w, 0);
      check("t3.main", {err_m, done_m}, 0);

      run(16'hFFFF, 16'd1, "t4");

      // Abort in the third CALC cycle.
      clean();
      load(16'd48, 16'd18);
      step();
      step();
      abort = 1'b1;
      #1;
      check("t5.noload", {ldA_m, ldB_m}, 0);
      a0 = regA;
      b0 = regB;
      step();
      abort = 1'b0;
      #1;
      check("t5.idle", op_ready_m, 1);
      repeat (10) step();
      check("t5.done", done_m, 0);
      check("t5.AB", {regA, regB}, {a0, b0});

      // Reset mid-CALC.
      clean();
      load(16'd48, 16'd18);
      step();
      reset_n = 1'b0;
      #1;
      check("t6.outs", {op_ready_m, ldA_m, ldB_m, sel1_m, sel2_m, sel_in_m, done_m, err_m}, 0);
      check("t6.wd", {op_ready_w, ldA_w, ldB_w, done_w, err_w}, 0);
      step();
      reset_n = 1'b1;
      #1;
      check("t6.rdy", op_ready_m, 1);
      run(16'd9, 16'd6, "t6");

      // op_valid held high while DONE.
      clean();
      load(16'd48, 16'd18);
      k = 0;
      while (!done_m && k < 20) begin
         step();
         k++;
      end
      check("t7.done", done_m, 1);
      op_valid = 1'b1;
      data_in  = 16'd999;
      #1;
      check("t7.rdy", op_ready_m, 0);
      check("t7.noload", {ldA_m, ldB_m}, 0);
      repeat (3) step();
      check("t7.A", regA, 6);
      check("t7.hold", done_m, 1);
      res_ack = 1'b1;
      #1;
      check("t7.ackload", {ldA_m, ldB_m}, 0);
      step();
      op_valid = 1'b0;
      res_ack  = 1'b0;
      check("t7.clr", done_m, 0);
      check("t7.A2", regA, 6);

      // No comparator flag asserted: handled as equal.
      clean();
      load(16'd48, 16'd18);
      force_none = 1'b1;
      #1;
      check("t8.noload", {ldA_m, ldB_m}, 0);
      step();
      force_none = 1'b0;
      check("t8.done", done_m, 1);
      check("t8.AB", {regA, regB}, {16'd48, 16'd18});
`ifdef GCD_ITER_COUNT_EN
      check("t8.iter", iter_count_m, 0);
`endif
      clean();

      for (int i = 0; i < 16; i++) begin
         run(16'($urandom_range(1, 300)), 16'($urandom_range(1, 300)), $sformatf("rnd%0d", i));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
